bus_demux4: RTL

//  Routes one CPU load/store to one of four memory-mapped targets (0 dmem, 1 IO, 2 timer, 3 spare)
//  and returns that target's read data and status. It is the 1-to-4 request side that pairs with the
//  mux2/mux4 data-return selection. It sits between the MEM stage and the targets. It has one

---
 rtl/bus_demux4.sv | 110 +++++++++++
 1 files changed

// File: rtl/bus_demux4.sv
// One-outstanding 1-to-4 request router between the MEM stage and four memory-mapped targets.
// Each transaction is forwarded to one target, waits for its ack or a timeout, then returns one response strobe.
module bus_demux4 #(
    parameter int SEL_MSB = 29,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [3:0]  t_req,
    output logic        t_we,
    output logic [31:0] t_addr,
    output logic [31:0] t_wdata,
    input  logic [3:0]  t_ack,
    input  logic [31:0] t_rdata0,
    input  logic [31:0] t_rdata1,
    input  logic [31:0] t_rdata2,
    input  logic [31:0] t_rdata3
);

    // A zero TIMEOUT still needs a one-bit counter so the declarations stay legal.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_reg;
    logic [1:0]       idx_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       req_idx;
    logic [127:0]     rdata_flat;
    logic [31:0]      rdata_arr [4];

    assign req_idx    = req_addr[SEL_MSB -: 2];
    assign rdata_flat = {t_rdata3, t_rdata2, t_rdata1, t_rdata0};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rdata
            assign rdata_arr[gi] = rdata_flat[gi*32 +: 32];
        end
    endgenerate

    assign req_ready = (state_reg == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= 2'd0;
            cnt_reg   <= '0;
            t_req     <= 4'd0;
            t_we      <= 1'b0;
            t_addr    <= 32'd0;
            t_wdata   <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        t_we      <= req_we;
                        t_addr    <= req_addr;
                        t_wdata   <= req_wdata;
                        idx_reg   <= req_idx;
                        t_req     <= 4'b0001 << req_idx;
                        cnt_reg   <= '0;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    // Ack is checked first so an ack on the timeout cycle still succeeds.
                    if (t_ack[idx_reg]) begin
                        t_req     <= 4'd0;
                        rsp_rdata <= t_we ? 32'd0 : rdata_arr[idx_reg];
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state_reg <= RESP;
                    end else if (TIMEOUT != 0 && cnt_reg == CNT_LAST) begin
                        t_req     <= 4'd0;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state_reg <= RESP;
                    end else if (TIMEOUT != 0) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
